// File: rtl/red_pitaya_adc_idly_train.sv
`default_nettype none
// ============================================================================
// red_pitaya_adc_idly_train : sweeps every IDELAY tap against the checkerboard
// pattern and centres each lane in its widest passing window.
// Optional macro ADC_IDLY_MANUAL_EN forwards man_*_i to the delay lines in IDLE/DONE.
// Revision: 1.0
// ============================================================================
module red_pitaya_adc_idly_train #(
    parameter int LANES  = 7,
    parameter int CNT_W  = 5,
    parameter int SETTLE = 16,
    parameter int WIN    = 64
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   start_i,
    input  logic [LANES-1:0]       adc_dat_i,
    input  logic [LANES-1:0]       man_rst_i,
    input  logic [LANES-1:0]       man_ce_i,
    input  logic [LANES-1:0]       man_inc_i,
    output logic [LANES-1:0]       idly_rst_o,
    output logic [LANES-1:0]       idly_ce_o,
    output logic [LANES-1:0]       idly_inc_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LANES-1:0]       fail_o,
    output logic [LANES*CNT_W-1:0] tap_o
);

    localparam int                 c_cnt_w       = $clog2(((SETTLE > WIN) ? SETTLE : WIN) + 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE - 1);
    localparam logic [c_cnt_w-1:0] c_win_last    = c_cnt_w'(WIN - 1);
    localparam logic [CNT_W-1:0]   c_tap_max     = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RST    = 4'd1,
        S_SETTLE = 4'd2,
        S_CHECK  = 4'd3,
        S_STEP   = 4'd4,
        S_EVAL   = 4'd5,
        S_CRST   = 4'd6,
        S_CINC   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [CNT_W-1:0]     r_tap;
    logic [CNT_W-1:0]     r_ccnt;
    logic [CNT_W-1:0]     w_max_tgt;
    logic [LANES-1:0]     r_prev;
    logic [LANES-1:0]     r_err;
    logic [LANES-1:0]     w_same;
    logic [LANES-1:0]     w_pass;
    logic [LANES-1:0]     w_cinc_mask;
    logic [LANES-1:0]     w_fail;
    logic [LANES*CNT_W-1:0] w_tgt;
    logic [LANES-1:0]     w_idly_rst;
    logic [LANES-1:0]     w_idly_ce;
    logic [LANES-1:0]     w_idly_inc;
    logic [LANES-1:0]     r_idly_rst;
    logic [LANES-1:0]     r_idly_ce;
    logic [LANES-1:0]     r_idly_inc;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_start_ok;
    logic                 w_cnt_clr;
    logic                 w_last_check;

    assign w_start_ok = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    // A lane errs whenever it fails to toggle between consecutive samples.
    assign w_same     = ~(adc_dat_i ^ r_prev);
    assign w_pass     = ~(r_err | w_same);

`ifndef ADC_IDLY_MANUAL_EN
    logic w_unused_man;
    assign w_unused_man = ^{man_rst_i, man_ce_i, man_inc_i};
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_clr    = 1'b0;
        w_last_check = 1'b0;
        w_idly_rst   = '0;
        w_idly_ce    = '0;
        w_idly_inc   = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_state_nxt = S_RST;
                end else begin
`ifdef ADC_IDLY_MANUAL_EN
                    w_idly_rst = man_rst_i;
                    w_idly_ce  = man_ce_i;
                    w_idly_inc = man_inc_i;
`endif
                end
            end
            S_RST: begin
                w_idly_rst  = '1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_cnt == c_win_last) begin
                    w_cnt_clr    = 1'b1;
                    w_last_check = 1'b1;
                    w_state_nxt  = (r_tap == c_tap_max) ? S_EVAL : S_STEP;
                end
            end
            S_STEP: begin
                w_idly_ce   = '1;
                w_idly_inc  = '1;
                w_state_nxt = S_SETTLE;
            end
            S_EVAL: begin
                w_state_nxt = S_CRST;
            end
            S_CRST: begin
                w_idly_rst  = '1;
                w_state_nxt = S_CINC;
            end
            S_CINC: begin
                w_idly_ce  = w_cinc_mask;
                w_idly_inc = w_cinc_mask;
                if (r_ccnt == w_max_tgt) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt  <= '0;
            r_tap  <= '0;
            r_ccnt <= '0;
            r_prev <= '0;
            r_err  <= '0;
        end else begin
            r_prev <= adc_dat_i;
            if (w_cnt_clr || !((r_state == S_SETTLE) || (r_state == S_CHECK))) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (r_state == S_RST) begin
                r_tap <= '0;
            end else if (r_state == S_STEP) begin
                r_tap <= r_tap + CNT_W'(1);
            end
            if (r_state == S_CRST) begin
                r_ccnt <= '0;
            end else if (r_state == S_CINC) begin
                r_ccnt <= r_ccnt + CNT_W'(1);
            end
            if (r_state == S_CHECK) begin
                r_err <= r_err | w_same;
            end else begin
                r_err <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_idly_rst <= '0;
            r_idly_ce  <= '0;
            r_idly_inc <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_idly_rst <= w_idly_rst;
            r_idly_ce  <= w_idly_ce;
            r_idly_inc <= w_idly_inc;
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [CNT_W:0]   r_cur_len;
            logic [CNT_W:0]   r_best_len;
            logic [CNT_W:0]   w_cur_len_nxt;
            logic [CNT_W-1:0] r_cur_start;
            logic [CNT_W-1:0] r_best_start;
            logic [CNT_W-1:0] w_run_start;
            logic [CNT_W-1:0] w_half;
            logic [CNT_W-1:0] r_target;
            logic             r_fail;

            assign w_cur_len_nxt = r_cur_len + (CNT_W+1)'(1);
            assign w_run_start   = (r_cur_len == '0) ? r_tap : r_cur_start;
            assign w_half        = CNT_W'((r_best_len - (CNT_W+1)'(1)) >> 1);

            // Strict compare keeps the earliest run on ties.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_cur_len    <= '0;
                    r_best_len   <= '0;
                    r_cur_start  <= '0;
                    r_best_start <= '0;
                end else if (r_state == S_RST) begin
                    r_cur_len    <= '0;
                    r_best_len   <= '0;
                    r_cur_start  <= '0;
                    r_best_start <= '0;
                end else if (w_last_check) begin
                    if (w_pass[l]) begin
                        r_cur_start <= w_run_start;
                        r_cur_len   <= w_cur_len_nxt;
                        if (w_cur_len_nxt > r_best_len) begin
                            r_best_len   <= w_cur_len_nxt;
                            r_best_start <= w_run_start;
                        end
                    end else begin
                        r_cur_len <= '0;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_fail   <= 1'b0;
                    r_target <= '0;
                end else if (w_start_ok) begin
                    r_fail <= 1'b0;
                end else if (r_state == S_EVAL) begin
                    if (r_best_len == '0) begin
                        r_fail   <= 1'b1;
                        r_target <= '0;
                    end else begin
                        r_fail   <= 1'b0;
                        r_target <= r_best_start + w_half;
                    end
                end
            end

            assign w_tgt[l*CNT_W +: CNT_W] = r_target;
            assign w_fail[l]               = r_fail;
            assign w_cinc_mask[l]          = (r_target > r_ccnt);
        end
    endgenerate

    always_comb begin
        w_max_tgt = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_tgt[l*CNT_W +: CNT_W] > w_max_tgt) begin
                w_max_tgt = w_tgt[l*CNT_W +: CNT_W];
            end
        end
    end

    assign idly_rst_o = r_idly_rst;
    assign idly_ce_o  = r_idly_ce;
    assign idly_inc_o = r_idly_inc;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign fail_o     = w_fail;
    assign tap_o      = w_tgt;

endmodule
`default_nettype wire

// File: doc/red_pitaya_adc_idly_train.md
# red_pitaya_adc_idly_train

Automatic input-delay training engine for one ADC data bus. It sits between the housekeeping register block and the per-lane IDELAY primitives. After a start pulse it sweeps every tap of all lanes in parallel against the ADC checkerboard test pattern, then sets each lane to the centre of its widest passing window. When not training, it forwards the housekeeping manual rst/ce/inc commands to the delay lines.

## Interface
Parameters:
- `LANES`, 7, number of data lanes (one IDELAY each)
- `CNT_W`, 5, tap counter width; the tap count is 2^CNT_W
- `SETTLE`, 16, cycles to wait after each tap change before checking
- `WIN`, 64, check-window length in cycles per tap

Ports:
- `clk_i`  in  1  ADC/system clock
- `rstn_i`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  one-cycle pulse that starts training
- `adc_dat_i`  in  LANES  one sampled bit per lane per clock; the ADC is in checkerboard test mode
- `man_rst_i`, `man_ce_i`, `man_inc_i`  in  LANES each  manual delay commands from the register block
- `idly_rst_o`, `idly_ce_o`, `idly_inc_o`  out  LANES each  registered commands to the IDELAYs
- `busy_o`  out  1  training in progress
- `done_o`  out  1  high from training completion until the next start or reset
- `fail_o`  out  LANES  lane had no passing tap
- `tap_o`  out  LANES*CNT_W  final tap chosen per lane; lane l occupies bits [l*CNT_W +: CNT_W]

## Operation
- States: IDLE, RST, SETTLE, CHECK, STEP, EVAL, CRST, CINC, DONE.
- **IDLE or DONE:** on `start_i`, go to RST. `done_o` falls and `fail_o` is cleared.
- **RST:** `idly_rst_o` is all ones for 1 cycle. The tap counter is set to 0. Go to SETTLE.
- **SETTLE:** wait `SETTLE` cycles, then go to CHECK.
- **CHECK:** run for `WIN` cycles. Per lane, the error flag is set if `adc_dat_i[l]` equals its value from the previous cycle. The first CHECK cycle compares against the last SETTLE sample. A lane passes the tap if its error flag is still clear at the end of the window.
- **Run tracking, per lane:**
  - Current run: start and length, with length CNT_W+1 bits wide.
  - On pass: the current run grows.
  - On fail: the current run resets to length 0.
  - The best run is replaced only when the current run is strictly longer, so on ties the first run is kept.
  - Runs do not wrap from the last tap to tap 0.
- **Tap advance:** if tap < 2^CNT_W−1, go to STEP. STEP pulses `idly_ce_o` and `idly_inc_o` on all lanes for 1 cycle, increments the tap counter, and goes to SETTLE. Otherwise go to EVAL.
- **EVAL (1 cycle):**
  - target = best_start + ((best_len−1)>>1).
  - If best_len = 0: the `fail_o` bit is set and target = 0.
- **CRST:** `idly_rst_o` is all ones for 1 cycle. The centring counter is set to 0.
- **CINC:** every cycle, `idly_ce_o`/`idly_inc_o` are high for each lane whose target is greater than the counter, and the counter increments. When the counter reaches the maximum target, go to DONE.
- **DONE:** `tap_o` holds the targets and `done_o` = 1.
- **Manual pass-through (IDLE/DONE only):** `idly_*_o` = `man_*_i`, registered with 1 cycle of latency. In all other states the manual inputs are ignored.
- **Edge cases:**
  - `start_i` while `busy_o` = 1 is ignored.
  - `start_i` coinciding with a manual command: start wins and the manual command is dropped.
  - Reset asserted mid-training aborts at once, with all outputs at their reset values. Delay lines keep their current taps until the next RST.
- **Reset values:** all `idly_*_o` = 0, `busy_o` = 0, `done_o` = 0, `fail_o` = 0, `tap_o` = 0. State = IDLE.

## Timing
- `busy_o` rises the cycle after `start_i` and falls on entry to DONE, in the same cycle `done_o` rises.
- Sweep length: 1 + 2^CNT_W·(SETTLE+WIN) + (2^CNT_W−1) cycles.
- EVAL: 1 cycle. CRST: 1 cycle. CINC: max(target)+1 cycles.
- Each `idly_ce_o`/`idly_inc_o` pulse is exactly 1 cycle and moves the delay by exactly 1 tap.
- `tap_o` and `fail_o` update in the EVAL cycle and are stable while `done_o` = 1.

## Configuration
- `ADC_IDLY_MANUAL_EN` defined: manual pass-through as described under Operation.
- `ADC_IDLY_MANUAL_EN` undefined: `man_*_i` are unused and `idly_*_o` are driven only by the trainer (0 in IDLE/DONE). Training behaviour is identical.

## Test plan
All scenarios use a bench IDELAY model, with SETTLE=4 and WIN=8.
- Lane 0 toggles correctly only for taps 10..20, other lanes for 0..31 -> `tap_o` lane 0 = 15, other lanes = 15, `fail_o` = 0, `done_o` = 1 after the computed cycle count.
- Lane 2 passes taps 0..3 and 28..31 -> tie, first run kept, tap = 1. Lane 3 passes 5..6 -> tap = 5.
- Lane 4 is held constant -> `fail_o[4]` = 1, `tap_o` lane 4 = 0, no CINC pulses on lane 4.
- Single stuck sample injected in CHECK at tap 12 on lane 1 (pass window 8..20) -> runs 8..11 and 13..20, tap = 16.
- In IDLE, `man_ce_i`=`man_inc_i`=7'h01 for 1 cycle -> `idly_ce_o`/`idly_inc_o` = 7'h01 one cycle later. With the macro undefined -> outputs stay 0.
- `rstn_i` low mid-sweep -> all outputs 0 asynchronously, state IDLE. A subsequent `start_i` completes normally. `start_i` during busy has no effect.
